// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg
// Types and constants shared by the cache memory responder and its array.
//   state_e         : responder FSM states (IDLE, WAIT, RESP)
//   ADDR_W / DATA_W : byte-addressed 256 x 8 storage
//   LATENCY_DEFAULT : default number of wait cycles before a response
//   UNWRITTEN_XOR   : pattern returned (XOR with address) for never-written bytes
package cache_mem_pkg;

    localparam int ADDR_W          = 8;
    localparam int DATA_W          = 8;
    localparam int LATENCY_DEFAULT = 3;

    localparam logic [DATA_W-1:0] UNWRITTEN_XOR = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Read value of a location that has not been written since reset.
    function automatic logic [DATA_W-1:0] unwritten_value(input logic [ADDR_W-1:0] addr);
        return DATA_W'(addr) ^ UNWRITTEN_XOR;
    endfunction

endpackage

// File: rtl/cache_mem_array.sv
// cache_mem_array
// 256 x 8 storage with a per-byte "written" bitmap.
//   clk       : clock
//   rst       : synchronous clear of the written bitmap (contents are kept)
//   we_i      : write strobe, updates data and sets the written bit
//   addr_i    : shared read/write address
//   wdata_i   : write data
//   rdata_o   : combinational read of the stored byte
//   written_o : combinational read of the written bit for addr_i
module cache_mem_array
    import cache_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              written_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  written_q;

    // Storage is deliberately not reset; the bitmap alone decides validity.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            written_q <= '0;
        end else if (we_i) begin
            written_q[addr_i] <= 1'b1;
        end
    end

    assign rdata_o   = mem_q[addr_i];
    assign written_o = written_q[addr_i];

endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder
// Fixed-latency memory responder for a cache controller. One request is
// accepted at a time, held for LATENCY enabled cycles, then answered.
//   clk, rst      : clock, synchronous active-high reset
//   ena           : enable; freezes the wait counter and blocks acceptance
//   req_valid/req_ready, req_we, req_addr, req_wdata : request channel
//   rsp_valid/rsp_ready, rsp_we, rsp_rdata           : response channel
//   busy          : high whenever a transaction is in flight
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);

    localparam logic [3:0] LAT_CNT  = 4'(LATENCY);
    localparam bit         ZERO_LAT = (LATENCY == 0);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_valid_q;
    logic              rsp_we_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic              accept;
    logic              enter_resp;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_written;
    logic [DATA_W-1:0] rsp_rdata_d;

    assign req_ready = (state_q == IDLE) && ena && !rst;
    assign busy      = (state_q != IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // A zero-latency build answers on the acceptance edge, before the request
    // fields have been latched, so the live inputs feed the array then.
    assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

    // Leaving WAIT happens on the edge where the counter steps from 1 to 0.
    assign enter_resp = (accept && ZERO_LAT)
                     || ((state_q == WAIT) && ena && (cnt_q == 4'd1) && !rst);

    // Writes commit only when the response is issued, so a reset during WAIT
    // discards them.
    assign mem_we = enter_resp && cur_we;

    assign rsp_rdata_d = cur_we      ? '0 :
                         mem_written ? mem_rdata :
                                       unwritten_value(cur_addr);

    cache_mem_array u_array (
        .clk       (clk),
        .rst       (rst),
        .we_i      (mem_we),
        .addr_i    (cur_addr),
        .wdata_i   (cur_wdata),
        .rdata_o   (mem_rdata),
        .written_o (mem_written)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (enter_resp) begin
                state_q     <= RESP;
                rsp_valid_q <= 1'b1;
                rsp_we_q    <= cur_we;
                rsp_rdata_q <= rsp_rdata_d;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q <= LAT_CNT;
                        if (!ZERO_LAT) begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (ena) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: a LATENCY=3 instance (index 0) and a
// LATENCY=0 instance (index 1) share clock and reset.
module tb_cache_mem_responder;

    logic clk = 1'b0;
    logic rst;

    logic       ena[2], req_valid[2], req_ready[2], req_we[2];
    logic       rsp_valid[2], rsp_ready[2], rsp_we[2], busy[2];
    logic [7:0] req_addr[2], req_wdata[2], rsp_rdata[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_mem_responder #(.LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .ena(ena[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_we(rsp_we[0]),
        .rsp_rdata(rsp_rdata[0]), .busy(busy[0])
    );

    cache_mem_responder #(.LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .ena(ena[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_we(rsp_we[1]),
        .rsp_rdata(rsp_rdata[1]), .busy(busy[1])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 3 : 0;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [7:0]   m_mem[2][256];
    bit   [255:0] m_wr[2];
    bit           m_busy[2], m_rsp[2], m_rwe[2], m_txwe[2];
    logic [7:0]   m_rdata[2], m_txaddr[2], m_txdata[2];
    int           m_left[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_wr[k] = '0; m_busy[k] = 0; m_rsp[k] = 0; m_rwe[k] = 0;
            m_rdata[k] = 8'h00; m_left[k] = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit fire;
            fire = 0;
            if (rst) begin
                m_busy[k] = 0; m_rsp[k] = 0; m_wr[k] = '0;
            end else if (m_rsp[k]) begin
                if (rsp_ready[k]) begin m_rsp[k] = 0; m_busy[k] = 0; end
            end else if (m_busy[k]) begin
                if (ena[k]) begin
                    m_left[k]--;
                    fire = (m_left[k] == 0);
                end
            end else if (req_valid[k] && ena[k]) begin
                m_busy[k] = 1; m_txwe[k] = req_we[k];
                m_txaddr[k] = req_addr[k]; m_txdata[k] = req_wdata[k];
                m_left[k] = lat_of(k);
                fire = (m_left[k] == 0);
            end
            if (fire) begin
                if (m_txwe[k]) begin
                    m_mem[k][m_txaddr[k]] = m_txdata[k];
                    m_wr[k][m_txaddr[k]] = 1'b1;
                    m_rdata[k] = 8'h00;
                end else begin
                    m_rdata[k] = m_wr[k][m_txaddr[k]] ? m_mem[k][m_txaddr[k]] : (m_txaddr[k] ^ 8'hFF);
                end
                m_rwe[k] = m_txwe[k];
                m_rsp[k] = 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("req_ready", k, req_ready[k], !m_busy[k] && ena[k] && !rst);
            chk("busy", k, busy[k], m_busy[k] && !rst);
            chk("rsp_valid", k, rsp_valid[k], m_rsp[k]);
            if (m_rsp[k]) begin
                chk("rsp_we", k, rsp_we[k], m_rwe[k]);
                chk("rsp_rdata", k, rsp_rdata[k], m_rdata[k]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int k, input logic we, input logic [7:0] a, input logic [7:0] d, output bit ok);
        int n;
        ok = 0; n = 0;
        ena[k] = 1; req_we[k] = we; req_addr[k] = a; req_wdata[k] = d; req_valid[k] = 1;
        while (!ok && n < 50) begin
            @(negedge clk);
            n++;
            ok = (req_ready[k] === 1'b1);
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            chk("accept", k, req_ready[k], 1);
            req_valid[k] = 0;
        end
    endtask

    task automatic finish(input int k, input int hold, input int gap, output logic [7:0] rd, output logic rwe);
        int lat, explat;
        bit seen;
        rsp_ready[k] = (hold == 0);
        // Junk request traffic while busy must be ignored.
        req_valid[k] = 1'($urandom); req_we[k] = 1'($urandom);
        req_addr[k] = 8'($urandom); req_wdata[k] = 8'($urandom);
        lat = 1; seen = 0;
        while (!seen && lat < 60) begin
            if (rsp_valid[k] === 1'b1) seen = 1;
            else begin
                ena[k] = !(lat >= 2 && lat < 2 + gap);
                @(posedge clk); #1;
                lat++;
            end
        end
        ena[k] = 1; req_valid[k] = 0;
        explat = lat_of(k) + 1 + ((lat_of(k) >= 2) ? gap : 0);
        chk("rsp_latency", k, lat, explat);
        rd = rsp_rdata[k]; rwe = rsp_we[k];
        for (int i = 0; i < hold; i++) begin
            ena[k] = 1'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", k, rsp_valid[k], 1);
            chk("hold_rdata", k, rsp_rdata[k], rd);
        end
        ena[k] = 1; rsp_ready[k] = 1;
        @(posedge clk); #1;
        rsp_ready[k] = 0;
        chk("idle_after_hs", k, busy[k], 0);
    endtask

    task automatic txn(input int k, input logic we, input logic [7:0] a, input logic [7:0] d,
                       input int hold, input int gap, output logic [7:0] rd, output logic rwe);
        bit ok;
        send(k, we, a, d, ok);
        rd = 8'hxx; rwe = 1'bx;
        if (ok) finish(k, hold, gap, rd, rwe);
    endtask

    initial begin
        logic [7:0] rd, a;
        logic       rwe;
        bit         ok;
        int         k;

        rst = 1;
        for (int j = 0; j < 2; j++) begin
            ena[j] = 1; req_valid[j] = 0; rsp_ready[j] = 0; req_we[j] = 0;
            req_addr[j] = 8'h00; req_wdata[j] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            chk("rst_rsp_valid", j, rsp_valid[j], 0);
            chk("rst_rsp_we", j, rsp_we[j], 0);
            chk("rst_rsp_rdata", j, rsp_rdata[j], 8'h00);
            chk("rst_busy", j, busy[j], 0);
            chk("rst_req_ready", j, req_ready[j], 0);
        end
        @(posedge clk); #1;
        rst = 0;
        #1;
        chk("post_rst_req_ready", 0, req_ready[0], 1);

        // Unwritten read, then write/readback, then top address.
        txn(0, 0, 8'h04, 8'h00, 0, 0, rd, rwe);  chk("rd04_unwritten", 0, rd, 8'hFB);
        txn(0, 1, 8'h04, 8'h5A, 0, 0, rd, rwe);  chk("wr04_ack_data", 0, rd, 8'h00);
        chk("wr04_ack_we", 0, rwe, 1);
        txn(0, 0, 8'h04, 8'h00, 0, 0, rd, rwe);  chk("rd04_written", 0, rd, 8'h5A);
        chk("rd04_we", 0, rwe, 0);
        txn(0, 1, 8'hFF, 8'h11, 0, 0, rd, rwe);  chk("wrFF_ack", 0, rd, 8'h00);
        txn(0, 0, 8'hFF, 8'h00, 0, 0, rd, rwe);  chk("rdFF", 0, rd, 8'h11);
        txn(0, 0, 8'h08, 8'h00, 0, 0, rd, rwe);  chk("rd08", 0, rd, 8'hF7);

        // Backpressure for 6 cycles, then an enable gap of 2 during WAIT.
        txn(0, 0, 8'h04, 8'h00, 6, 0, rd, rwe);  chk("rd04_held", 0, rd, 8'h5A);
        txn(0, 0, 8'h08, 8'h00, 0, 2, rd, rwe);  chk("rd08_gap", 0, rd, 8'hF7);

        // Reset in the middle of a pending write.
        send(0, 1, 8'h10, 8'h77, ok);
        req_valid[0] = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_no_rsp", 0, rsp_valid[0], 0);
            chk("abort_idle", 0, busy[0], 0);
        end
        txn(0, 0, 8'h10, 8'h00, 0, 0, rd, rwe);  chk("rd10_after_abort", 0, rd, 8'hEF);
        txn(0, 0, 8'h04, 8'h00, 0, 0, rd, rwe);  chk("rd04_after_rst", 0, rd, 8'hFB);

        // Zero-latency instance, back-to-back reads.
        txn(1, 0, 8'h00, 8'h00, 0, 0, rd, rwe);  chk("l0_rd00", 1, rd, 8'hFF);
        txn(1, 0, 8'h01, 8'h00, 0, 0, rd, rwe);  chk("l0_rd01", 1, rd, 8'hFE);

        // Randomized traffic on a small address pool so reads hit earlier writes.
        for (int i = 0; i < 160; i++) begin
            k = i % 2;
            a = ($urandom_range(0, 3) == 0) ? (8'hFF - 8'($urandom_range(0, 1))) : 8'($urandom_range(0, 7));
            txn(k, 1'($urandom), a, 8'($urandom), $urandom_range(0, 3),
                (k == 0) ? $urandom_range(0, 2) : 0, rd, rwe);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
